// File: rtl/execution_stage_if.sv
// Decode-to-execute-to-memory bundle for the 8-bit pipeline's execute stage.
interface execution_stage_if #(
   parameter int WIDTH    = 8,
   parameter int REG_BITS = 5
);
   logic                valid_in;
   logic [WIDTH-1:0]    A_in;
   logic [WIDTH-1:0]    B_in;
   logic [WIDTH-1:0]    imm_in;
   logic                imm_sel;
   logic [2:0]          alu_sel;
   logic [REG_BITS-1:0] RW_in;
   logic                mem_en_in;
   logic                mem_rw_in;
   logic                mem_mux_sel_in;
   logic                stall;
   logic [WIDTH-1:0]    ans_ex;
   logic [WIDTH-1:0]    B_bypass;
   logic [REG_BITS-1:0] RW_ex;
   logic                mem_en_ex;
   logic                mem_rw_ex;
   logic                mem_mux_sel_ex;
   logic                zero_ex;

   modport master (
      output valid_in, A_in, B_in, imm_in, imm_sel, alu_sel, RW_in,
             mem_en_in, mem_rw_in, mem_mux_sel_in,
      input  stall, ans_ex, B_bypass, RW_ex, mem_en_ex, mem_rw_ex,
             mem_mux_sel_ex, zero_ex
   );

   modport slave (
      input  valid_in, A_in, B_in, imm_in, imm_sel, alu_sel, RW_in,
             mem_en_in, mem_rw_in, mem_mux_sel_in,
      output stall, ans_ex, B_bypass, RW_ex, mem_en_ex, mem_rw_ex,
             mem_mux_sel_ex, zero_ex
   );
endinterface

// File: rtl/execution_stage.sv
// Execute stage: single-cycle ALU plus an 8-step shift-add multiplier that
// stalls decode while it iterates.
//
// state   | meaning
// IDLE    | single-cycle ops retire directly; a MUL is accepted here
// MUL_RUN | one shift-add step per edge; final step retires the product
module execution_stage #(
   parameter int WIDTH     = 8,
   parameter int REG_BITS  = 5,
   parameter int MUL_STEPS = 8
) (
   input  logic            clk3,
   input  logic            reset,
   execution_stage_if.slave ex
);
   localparam int CNT_W = $clog2(MUL_STEPS);
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic {IDLE, MUL_RUN} state_t;
   typedef enum logic [1:0] {OUT_BUBBLE, OUT_ALU, OUT_MUL} out_sel_t;

   state_t              state, state_next;
   out_sel_t            out_sel;
   logic                mul_start, mul_step, last_step, stall;

   logic [WIDTH-1:0]    op2, alu_result, acc_next;
   logic [WIDTH-1:0]    mcand, mplier, acc;
   logic [CNT_W-1:0]    count;

   logic [WIDTH-1:0]    cap_b;
   logic [REG_BITS-1:0] cap_rw;
   logic                cap_mem_en, cap_mem_rw, cap_mem_mux;

   assign op2       = ex.imm_sel ? ex.imm_in : ex.B_in;
   assign last_step = (count == CNT_W'(MUL_STEPS - 1));
   assign acc_next  = acc + (mplier[0] ? mcand : '0);
   assign ex.stall  = stall;

   always_comb begin
      alu_result = '0;
      case (ex.alu_sel)
         3'b000:  alu_result = ex.A_in + op2;
         3'b001:  alu_result = ex.A_in - op2;
         3'b010:  alu_result = ex.A_in & op2;
         3'b011:  alu_result = ex.A_in | op2;
         3'b100:  alu_result = ex.A_in ^ op2;
         3'b101:  alu_result = ex.A_in << op2[2:0];
         3'b110:  alu_result = ex.A_in >> op2[2:0];
         default: alu_result = '0;   // MUL goes through the iterative path
      endcase
   end

   always_ff @(posedge clk3 or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (ex.valid_in && ex.alu_sel == OP_MUL) state_next = MUL_RUN;
         MUL_RUN: if (last_step) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // stall drops in the final step so decode advances on the retiring edge
   always_comb begin
      stall     = 1'b0;
      out_sel   = OUT_BUBBLE;
      mul_start = 1'b0;
      mul_step  = 1'b0;
      case (state)
         IDLE: begin
            if (ex.valid_in) begin
               if (ex.alu_sel == OP_MUL) begin
                  stall     = 1'b1;
                  mul_start = 1'b1;
               end else begin
                  out_sel = OUT_ALU;
               end
            end
         end
         MUL_RUN: begin
            mul_step = 1'b1;
            if (last_step) out_sel = OUT_MUL;
            else           stall   = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk3 or posedge reset) begin
      if (reset) begin
         mcand             <= '0;
         mplier            <= '0;
         acc               <= '0;
         count             <= '0;
         cap_b             <= '0;
         cap_rw            <= '0;
         cap_mem_en        <= 1'b0;
         cap_mem_rw        <= 1'b0;
         cap_mem_mux       <= 1'b0;
         ex.ans_ex         <= '0;
         ex.B_bypass       <= '0;
         ex.RW_ex          <= '0;
         ex.mem_en_ex      <= 1'b0;
         ex.mem_rw_ex      <= 1'b0;
         ex.mem_mux_sel_ex <= 1'b0;
         ex.zero_ex        <= 1'b0;
      end else begin
         if (mul_start) begin
            mcand       <= ex.A_in;
            mplier      <= op2;
            acc         <= '0;
            count       <= '0;
            cap_b       <= ex.B_in;
            cap_rw      <= ex.RW_in;
            cap_mem_en  <= ex.mem_en_in;
            cap_mem_rw  <= ex.mem_rw_in;
            cap_mem_mux <= ex.mem_mux_sel_in;
         end else if (mul_step) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CNT_W'(1);
         end

         case (out_sel)
            OUT_ALU: begin
               ex.ans_ex         <= alu_result;
               ex.B_bypass       <= ex.B_in;
               ex.RW_ex          <= ex.RW_in;
               ex.mem_en_ex      <= ex.mem_en_in;
               ex.mem_rw_ex      <= ex.mem_rw_in;
               ex.mem_mux_sel_ex <= ex.mem_mux_sel_in;
               ex.zero_ex        <= (alu_result == '0);
            end
            OUT_MUL: begin
               ex.ans_ex         <= acc_next;
               ex.B_bypass       <= cap_b;
               ex.RW_ex          <= cap_rw;
               ex.mem_en_ex      <= cap_mem_en;
               ex.mem_rw_ex      <= cap_mem_rw;
               ex.mem_mux_sel_ex <= cap_mem_mux;
               ex.zero_ex        <= (acc_next == '0);
            end
            default: begin
               ex.ans_ex         <= '0;
               ex.B_bypass       <= '0;
               ex.RW_ex          <= '0;
               ex.mem_en_ex      <= 1'b0;
               ex.mem_rw_ex      <= 1'b0;
               ex.mem_mux_sel_ex <= 1'b0;
               ex.zero_ex        <= 1'b0;
            end
         endcase
      end
   end
endmodule
